ones_pattern_gen: RTL and testbench

Sequential generator that is the inverse of the popcount block. Given a requested ones count k, it streams every WIDTH-bit word containing exactly k set bits, in ascending numeric order, over a valid/ready interface. It serves as a stimulus source and checker companion for ones-counting logic and pattern-based test generation.

---
 rtl/ones_pattern_gen_if.sv | 27 ++
 rtl/ones_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_ones_pattern_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_gen_if.sv
// Output stream of the ones-pattern generator: one word per valid/ready handshake,
// tagged with its ordinal and an end-of-sequence marker.
interface ones_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [WIDTH-1:0] out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// Streams every WIDTH-bit word with exactly k set bits in ascending order.
// A one-deep match stage (_p1) sits between the candidate counter and the output word.
module ones_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    ones_pattern_gen_if.master bus
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Highest word with kk ones: all of them packed against the MSB.
    function automatic logic [WIDTH-1:0] last_word(input logic [CNT_W-1:0] kk);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = (i >= (WIDTH - int'(kk)));
        end
        return w;
    endfunction

    state_t           state, state_nx;
    logic [WIDTH-1:0] cand, cand_nx;
    logic [CNT_W-1:0] k_reg, k_reg_nx;
    logic             vld_p1, vld_p1_nx;
    logic             hit_p1, hit_p1_nx;
    logic [WIDTH-1:0] data_p1, data_p1_nx;
    logic [WIDTH-1:0] data_q, data_nx;
    logic             valid_q, valid_nx;
    logic             last_q, last_nx;
    logic [WIDTH-1:0] index_q, index_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             err_q, err_nx;

    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        k_reg_nx   = k_reg;
        vld_p1_nx  = 1'b0;
        hit_p1_nx  = hit_p1;
        data_p1_nx = data_p1;
        data_nx    = data_q;
        valid_nx   = valid_q;
        last_nx    = last_q;
        index_nx   = index_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (k > WIDTH_C) begin
                        err_nx = 1'b1;
                    end else begin
                        k_reg_nx = k;
                        cand_nx  = '0;
                        index_nx = '0;
                        busy_nx  = 1'b1;
                        state_nx = SCAN;
                    end
                end
            end
            SCAN: begin
                // cand already points one past data_p1, so a hit leaves it ready to resume
                if (vld_p1 && hit_p1) begin
                    data_nx  = data_p1;
                    valid_nx = 1'b1;
                    last_nx  = (data_p1 == last_word(k_reg));
                    state_nx = HOLD;
                end else begin
                    vld_p1_nx  = 1'b1;
                    hit_p1_nx  = (popcount(cand) == k_reg);
                    data_p1_nx = cand;
                    cand_nx    = (cand == ALL_ONES) ? cand : cand + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_nx = 1'b0;
                    if (last_q) begin
                        last_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        index_nx = index_q + 1'b1;
                        state_nx = SCAN;
                    end
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cand    <= '0;
            k_reg   <= '0;
            vld_p1  <= 1'b0;
            hit_p1  <= 1'b0;
            data_p1 <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cand    <= cand_nx;
            k_reg   <= k_reg_nx;
            vld_p1  <= vld_p1_nx;
            hit_p1  <= hit_p1_nx;
            data_p1 <= data_p1_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            last_q  <= last_nx;
            index_q <= index_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_index = index_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: a word-list model built from $countones drives a
// negedge compare process; directed sequences add literal latency/count pins.
module tb_ones_pattern_gen;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] k;
    logic             busy;
    logic             done;
    logic             err;

    ones_pattern_gen_if #(.WIDTH(WIDTH)) bus ();

    ones_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_idx;
    int               word_cnt;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] final_word;
    bit               seq_finished;
    bit               mon_en;
    bit               stall_mode;
    bit               ready_hi;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_mode) bus.out_ready = 1'($urandom_range(0, 1));
        else            bus.out_ready = ready_hi;
    end

    // Compare process
    bit               held;
    bit               last_hs;
    logic [WIDTH-1:0] h_data;
    logic [WIDTH-1:0] h_idx;
    logic             h_last;
    logic [WIDTH-1:0] w_exp;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            held    = 1'b0;
            last_hs = 1'b0;
        end else begin
            chk("done_pulse", done, last_hs);
            if (last_hs) seq_finished = 1'b1;
            last_hs = 1'b0;
            if (held) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, h_data);
                chk("stall_index", bus.out_index, h_idx);
                chk("stall_last", bus.out_last, h_last);
            end
            held = 1'b0;
            if (bus.out_valid) begin
                chk("busy_with_valid", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", bus.out_data, 'hDEAD);
                end else if (bus.out_ready) begin
                    w_exp = exp_q.pop_front();
                    chk("word_data", bus.out_data, w_exp);
                    chk("word_index", bus.out_index, exp_idx);
                    chk("word_last", bus.out_last, exp_q.size() == 0);
                    if (exp_idx == 0) first_word = bus.out_data;
                    final_word = bus.out_data;
                    exp_idx++;
                    word_cnt++;
                    if (exp_q.size() == 0) last_hs = 1'b1;
                end else begin
                    held   = 1'b1;
                    h_data = bus.out_data;
                    h_idx  = bus.out_index;
                    h_last = bus.out_last;
                end
            end
        end
    end

    task automatic pulse_start(input int kv);
        @(posedge clk);
        #1;
        start = 1'b1;
        k     = CNT_W'(kv);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_seq(input int kv, input bit stall, input bit poke, output int lat);
        logic [WIDTH-1:0] wv;
        exp_q.delete();
        for (int w = 0; w < (1 << WIDTH); w++) begin
            wv = WIDTH'(w);
            if ($countones(wv) == kv) exp_q.push_back(wv);
        end
        exp_idx      = 0;
        word_cnt     = 0;
        seq_finished = 1'b0;
        stall_mode   = stall;
        ready_hi     = 1'b1;
        mon_en       = 1'b1;
        lat          = -1;
        pulse_start(kv);
        chk("busy_after_start", busy, 1);
        for (int c = 0; c < 5000 && !seq_finished; c++) begin
            @(posedge clk);
            #1;
            start = poke && (c == 20);
            if (poke && c == 20) k = 2;
            if (lat < 0 && bus.out_valid) lat = c + 1;
        end
        chk("seq_finished", seq_finished, 1);
        chk("busy_after_done", busy, 0);
        chk("words_left", exp_q.size(), 0);
        stall_mode = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_index"}, bus.out_index, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    int lat;

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        k             = '0;
        bus.out_ready = 1'b0;
        mon_en        = 1'b0;
        stall_mode    = 1'b0;
        ready_hi      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_seq(0, 0, 0, lat);
        chk("k0_latency", lat, 2);
        chk("k0_words", word_cnt, 1);
        chk("k0_first", first_word, 'h00);

        run_seq(1, 0, 0, lat);
        chk("k1_latency", lat, 3);
        chk("k1_words", word_cnt, 8);
        chk("k1_first", first_word, 'h01);
        chk("k1_final", final_word, 'h80);

        run_seq(8, 0, 0, lat);
        chk("k8_latency", lat, 257);
        chk("k8_words", word_cnt, 1);
        chk("k8_first", first_word, 'hFF);

        run_seq(4, 1, 1, lat);
        chk("k4_words", word_cnt, 70);
        chk("k4_first", first_word, 'h0F);
        chk("k4_final", final_word, 'hF0);

        pulse_start(9);
        chk("k9_err", err, 1);
        chk("k9_busy", busy, 0);
        chk("k9_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("k9_err_clear", err, 0);
        chk("k9_busy_after", busy, 0);

        mon_en   = 1'b0;
        ready_hi = 1'b0;
        pulse_start(3);
        for (int c = 0; c < 100 && !bus.out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("k3_hold_valid", bus.out_valid, 1);
        chk("k3_hold_data", bus.out_data, 'h07);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midreset");
        rst_n = 1'b1;

        run_seq(2, 0, 0, lat);
        chk("k2_latency", lat, 5);
        chk("k2_words", word_cnt, 28);
        chk("k2_first", first_word, 'h03);
        chk("k2_final", final_word, 'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
